// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu converter blocks.
// Float constants, handshake widths and converter FSM encodings.
package fpu_pkg;

   localparam int WORD_W     = 32;
   localparam int STB_W      = 1;
   localparam int ACK_W      = 1;
   localparam int MANT_W     = 24;
   localparam int EXP_W      = 10;
   localparam int FLOAT_BIAS = 127;

   localparam logic [WORD_W-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      GET_A   = 3'd0,
      UNPACK  = 3'd1,
      SPECIAL = 3'd2,
      CONVERT = 3'd3,
      PUT_Z   = 3'd4
   } f2i_state_e;

endpackage

// File: rtl/f2i_shift.sv
// Bidirectional barrel shifter for float-to-int conversion.
// Aligns the 24-bit mantissa to the integer point for 0 <= e <= 30.
import fpu_pkg::*;

module f2i_shift (
   input  logic        [MANT_W-1:0] m_i,
   input  logic signed [EXP_W-1:0]  e_i,
   output logic        [WORD_W-1:0] mag_o
);

   logic [WORD_W-1:0] m_ext;
   logic [4:0]        lsh;
   logic [4:0]        rsh;

   assign m_ext = {8'b0, m_i};

   // Left shift for e >= 23, right shift otherwise; fraction bits fall off.
   always_comb begin
      lsh   = e_i[4:0] - 5'd23;
      rsh   = 5'd23 - e_i[4:0];
      mag_o = '0;
      if (e_i >= 10'sd23) begin
         mag_o = m_ext << lsh;
      end else begin
         mag_o = m_ext >> rsh;
      end
   end

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero.
// Multi-cycle FSM with stb/ack handshakes on input and output.
import fpu_pkg::*;

module float_to_int (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] input_a,
   input  logic              input_a_stb,
   output logic              input_a_ack,
   output logic [WORD_W-1:0] output_z,
   output logic              output_z_stb,
   input  logic              output_z_ack
);

   f2i_state_e state_q;

   logic                     ack_q;
   logic                     stb_q;
   logic [WORD_W-1:0]        z_q;
   logic [WORD_W-1:0]        a_q;
   logic                     s_q;
   logic [MANT_W-1:0]        m_q;
   logic signed [EXP_W-1:0]  e_q;

   logic signed [EXP_W-1:0]  e_d;
   logic [WORD_W-1:0]        mag_d;
   logic [WORD_W-1:0]        conv_d;

   assign e_d = $signed({2'b00, a_q[30:23]}) - 10'(FLOAT_BIAS);

   f2i_shift u_shift (
      .m_i   (m_q),
      .e_i   (e_q),
      .mag_o (mag_d)
   );

   assign conv_d = s_q ? (~mag_d + 32'd1) : mag_d;

   assign input_a_ack  = ack_q;
   assign output_z_stb = stb_q;
   assign output_z     = z_q;

   // Conversion sequencer with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GET_A;
         ack_q   <= 1'b0;
         stb_q   <= 1'b0;
         z_q     <= '0;
         a_q     <= '0;
         s_q     <= 1'b0;
         m_q     <= '0;
         e_q     <= '0;
      end else begin
         unique case (state_q)
            GET_A: begin
               ack_q <= 1'b1;
               if (ack_q && input_a_stb) begin
                  a_q     <= input_a;
                  ack_q   <= 1'b0;
                  state_q <= UNPACK;
               end
            end
            UNPACK: begin
               s_q     <= a_q[31];
               m_q     <= {1'b1, a_q[22:0]};
               e_q     <= e_d;
               state_q <= SPECIAL;
            end
            SPECIAL: begin
               if (a_q[30:23] == 8'd0 || e_q < 10'sd0) begin
                  z_q     <= '0;
                  stb_q   <= 1'b1;
                  state_q <= PUT_Z;
               end else if (e_q >= 10'sd31) begin
                  z_q     <= INT_MIN;
                  stb_q   <= 1'b1;
                  state_q <= PUT_Z;
               end else begin
                  state_q <= CONVERT;
               end
            end
            CONVERT: begin
               z_q     <= conv_d;
               stb_q   <= 1'b1;
               state_q <= PUT_Z;
            end
            PUT_Z: begin
               if (stb_q && output_z_ack) begin
                  stb_q   <= 1'b0;
                  state_q <= GET_A;
               end
            end
            default: state_q <= GET_A;
         endcase
      end
   end

endmodule
